// File: rtl/bsg_level_shift_pkg.sv
// Shared types for the sequenced v0->v1 level-shift isolation cell.
// State enum plus fixed encodings for verification binding.
package bsg_level_shift_pkg;

   typedef enum logic [1:0] {
      eIso    = 2'd0,
      eSettle = 2'd1,
      eOn     = 2'd2,
      ePdnAck = 2'd3
   } bsg_iso_state_e;

   localparam logic [1:0] LS_ST_ISO    = 2'd0;
   localparam logic [1:0] LS_ST_SETTLE = 2'd1;
   localparam logic [1:0] LS_ST_ON     = 2'd2;
   localparam logic [1:0] LS_ST_PDNACK = 2'd3;

endpackage

// File: rtl/bsg_level_shift_iso_fsm.sv
// Isolation sequencer: settle counter, power-down handshake,
// registered iso/ack outputs and a next-state-is-ON strobe.
import bsg_level_shift_pkg::*;

module bsg_level_shift_iso_fsm #(
   parameter int unsigned settle_cycles_p = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic v0_pwr_good_i,
   input  logic pdn_req_i,
   output logic on_nxt_o,
   output logic iso_o,
   output logic pdn_ack_o
);

   localparam int unsigned CW = $clog2(settle_cycles_p + 1);
   localparam logic [CW-1:0] LAST = CW'(settle_cycles_p - 1);

   bsg_iso_state_e r_state, w_nxt;
   logic [CW-1:0]  r_cnt, w_cnt_nxt;
   logic           w_ok;

   assign w_ok = v0_pwr_good_i & ~pdn_req_i;

   always_comb begin
      w_nxt     = r_state;
      w_cnt_nxt = r_cnt;
      unique case (r_state)
         eIso: begin
            if (w_ok) begin
               w_nxt     = eSettle;
               w_cnt_nxt = '0;
            end
         end
         eSettle: begin
            if (!w_ok) begin
               w_nxt     = eIso;
               w_cnt_nxt = '0;
            end else if (r_cnt == LAST) begin
               w_nxt     = eOn;
               w_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         // Unplanned supply loss beats a pending power-down request.
         eOn: begin
            if (!v0_pwr_good_i)
               w_nxt = eIso;
            else if (pdn_req_i)
               w_nxt = ePdnAck;
         end
         ePdnAck: begin
            if (!pdn_req_i)
               w_nxt = eIso;
         end
         default: begin
            w_nxt     = eIso;
            w_cnt_nxt = '0;
         end
      endcase
   end

   assign on_nxt_o = (w_nxt == eOn);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state   <= eIso;
         r_cnt     <= '0;
         iso_o     <= 1'b1;
         pdn_ack_o <= 1'b0;
      end else begin
         r_state   <= w_nxt;
         r_cnt     <= w_cnt_nxt;
         iso_o     <= (w_nxt != eOn);
         pdn_ack_o <= (w_nxt == ePdnAck);
      end
   end

endmodule

// File: rtl/bsg_level_shift_iso_seq.sv
// Sequenced level-shift source cell on the v0->v1 boundary;
// owns the registered clamp mux for data and valid.
import bsg_level_shift_pkg::*;

module bsg_level_shift_iso_seq #(
   parameter int unsigned            width_p         = 16,
   parameter logic [width_p-1:0]     clamp_val_p     = '0,
   parameter int unsigned            settle_cycles_p = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v0_pwr_good_i,
   input  logic               pdn_req_i,
   input  logic               v0_en_i,
   input  logic [width_p-1:0] v0_data_i,
   output logic [width_p-1:0] v1_data_o,
   output logic               v1_valid_o,
   output logic               iso_o,
   output logic               pdn_ack_o
);

   logic w_on_nxt;
   logic w_live;

   bsg_level_shift_iso_fsm #(
      .settle_cycles_p(settle_cycles_p)
   ) u_fsm (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .v0_pwr_good_i(v0_pwr_good_i),
      .pdn_req_i    (pdn_req_i),
      .on_nxt_o     (w_on_nxt),
      .iso_o        (iso_o),
      .pdn_ack_o    (pdn_ack_o)
   );

   // v0 inputs are only looked at when the boundary will be open.
   assign w_live = w_on_nxt & v0_en_i;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         v1_data_o  <= clamp_val_p;
         v1_valid_o <= 1'b0;
      end else begin
         v1_data_o  <= w_live ? v0_data_i : clamp_val_p;
         v1_valid_o <= w_live;
      end
   end

endmodule

// File: tb/tb_bsg_level_shift_iso_seq.sv
// Bench for bsg_level_shift_iso_seq: directed table, random run
// against a behavioural model, two parameterisations side by side.
module tb_bsg_level_shift_iso_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        g, r, en;
   logic [15:0] d;
   logic [15:0] data0, data1;
   logic        val0, val1, iso0, iso1, ack0, ack1;

   always #5 clk = ~clk;

   bsg_level_shift_iso_seq dut0 (
      .clk_i(clk), .reset_i(reset),
      .v0_pwr_good_i(g), .pdn_req_i(r),
      .v0_en_i(en), .v0_data_i(d),
      .v1_data_o(data0), .v1_valid_o(val0),
      .iso_o(iso0), .pdn_ack_o(ack0)
   );

   bsg_level_shift_iso_seq #(
      .width_p(16), .clamp_val_p(16'hFFFF), .settle_cycles_p(1)
   ) dut1 (
      .clk_i(clk), .reset_i(reset),
      .v0_pwr_good_i(g), .pdn_req_i(r),
      .v0_en_i(en), .v0_data_i(d),
      .v1_data_o(data1), .v1_valid_o(val1),
      .iso_o(iso1), .pdn_ack_o(ack1)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Model: live = boundary open, ack = handshake owed,
   // run = good cycles seen in settle (-1 when isolated/idle).
   int          m_run[2];
   bit          m_live[2];
   bit          m_ack[2];
   int          m_S[2];
   logic [15:0] m_clamp[2];

   function automatic void mdl_reset();
      for (int i = 0; i < 2; i++) begin
         m_live[i] = 0;
         m_ack[i]  = 0;
         m_run[i]  = -1;
      end
   endfunction

   function automatic void mdl_edge();
      for (int i = 0; i < 2; i++) begin
         if (m_ack[i]) begin
            if (!r) m_ack[i] = 0;
         end else if (m_live[i]) begin
            if (!g) m_live[i] = 0;
            else if (r) begin
               m_live[i] = 0;
               m_ack[i]  = 1;
            end
         end else if (m_run[i] < 0) begin
            if (g && !r) m_run[i] = 0;
         end else if (!g || r) begin
            m_run[i] = -1;
         end else begin
            m_run[i]++;
            if (m_run[i] == m_S[i]) begin
               m_live[i] = 1;
               m_run[i]  = -1;
            end
         end
      end
   endfunction

   task automatic cmp(input string nm,
                      input logic ai, av, aa,
                      input logic [15:0] ad,
                      input logic ei, ev, ea,
                      input logic [15:0] ed);
      n_vec++;
      if ({ai, av, aa, ad} !== {ei, ev, ea, ed}) begin
         n_bad++;
         $display("FAIL %s: got iso=%b valid=%b ack=%b data=%h, want iso=%b valid=%b ack=%b data=%h",
                  nm, ai, av, aa, ad, ei, ev, ea, ed);
      end
   endtask

   task automatic chk_model(input string nm);
      logic [15:0] e0, e1;
      e0 = (m_live[0] && en) ? d : m_clamp[0];
      e1 = (m_live[1] && en) ? d : m_clamp[1];
      cmp({nm, "/dut0"}, iso0, val0, ack0, data0,
          !m_live[0], m_live[0] && en, m_ack[0], e0);
      cmp({nm, "/dut1"}, iso1, val1, ack1, data1,
          !m_live[1], m_live[1] && en, m_ack[1], e1);
   endtask

   task automatic step(input logic ig, ir, ien,
                       input logic [15:0] id);
      g  = ig;
      r  = ir;
      en = ien;
      d  = id;
      @(posedge clk);
      mdl_edge();
      #1;
   endtask

   typedef struct {
      logic        g, r, en;
      logic [15:0] d;
      logic        iso, valid, ack;
      logic [15:0] dat;
   } vec_t;

   vec_t tbl[21];

   initial begin
      m_S[0] = 4;  m_clamp[0] = 16'h0000;
      m_S[1] = 1;  m_clamp[1] = 16'hFFFF;

      tbl[0]  = '{1,0,1,16'hA5C3, 1,0,0,16'h0000};
      tbl[1]  = '{1,0,1,16'hA5C3, 1,0,0,16'h0000};
      tbl[2]  = '{1,0,1,16'hA5C3, 1,0,0,16'h0000};
      tbl[3]  = '{1,0,1,16'hA5C3, 1,0,0,16'h0000};
      tbl[4]  = '{1,0,1,16'hA5C3, 0,1,0,16'hA5C3};
      tbl[5]  = '{1,0,0,16'hA5C3, 0,0,0,16'h0000};
      tbl[6]  = '{1,0,1,16'h1234, 0,1,0,16'h1234};
      tbl[7]  = '{1,1,1,16'h1234, 1,0,1,16'h0000};
      tbl[8]  = '{0,1,1,16'h1234, 1,0,1,16'h0000};
      tbl[9]  = '{1,0,1,16'h1234, 1,0,0,16'h0000};
      tbl[10] = '{1,0,1,16'hBEEF, 1,0,0,16'h0000};
      tbl[11] = '{1,0,1,16'hBEEF, 1,0,0,16'h0000};
      tbl[12] = '{1,0,1,16'hBEEF, 1,0,0,16'h0000};
      tbl[13] = '{0,0,1,16'hBEEF, 1,0,0,16'h0000};
      tbl[14] = '{1,0,1,16'hBEEF, 1,0,0,16'h0000};
      tbl[15] = '{1,0,1,16'hBEEF, 1,0,0,16'h0000};
      tbl[16] = '{1,0,1,16'hBEEF, 1,0,0,16'h0000};
      tbl[17] = '{1,0,1,16'hBEEF, 1,0,0,16'h0000};
      tbl[18] = '{1,0,1,16'hBEEF, 0,1,0,16'hBEEF};
      tbl[19] = '{0,1,1,16'hBEEF, 1,0,0,16'h0000};
      tbl[20] = '{0,0,1,16'hBEEF, 1,0,0,16'h0000};

      reset = 1'b1;
      g = 0; r = 0; en = 0; d = '0;
      mdl_reset();
      #2;
      cmp("reset0", iso0, val0, ack0, data0, 1, 0, 0, 16'h0000);
      cmp("reset1", iso1, val1, ack1, data1, 1, 0, 0, 16'hFFFF);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 21; i++) begin
         step(tbl[i].g, tbl[i].r, tbl[i].en, tbl[i].d);
         cmp($sformatf("tbl%0d", i), iso0, val0, ack0, data0,
             tbl[i].iso, tbl[i].valid, tbl[i].ack, tbl[i].dat);
         chk_model($sformatf("tblm%0d", i));
      end

      // Reset asserted mid-ON must clamp without a clock edge.
      for (int i = 0; i < 6; i++) step(1, 0, 1, 16'h1234);
      cmp("on_pre_rst", iso1, val1, ack1, data1, 0, 1, 0, 16'h1234);
      reset = 1'b1;
      #1;
      mdl_reset();
      cmp("async_rst1", iso1, val1, ack1, data1, 1, 0, 0, 16'hFFFF);
      cmp("async_rst0", iso0, val0, ack0, data0, 1, 0, 0, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
      step(1, 0, 1, 16'h1234);
      cmp("rst_settle1", iso1, val1, ack1, data1, 1, 0, 0, 16'hFFFF);
      step(1, 0, 1, 16'h1234);
      cmp("rst_on1", iso1, val1, ack1, data1, 0, 1, 0, 16'h1234);

      // Random run; pdn_req is held a while once raised.
      r = 0;
      for (int i = 0; i < 600; i++) begin
         logic nr;
         nr = r ? ($urandom_range(0, 2) != 0)
                : ($urandom_range(0, 7) == 0);
         step($urandom_range(0, 9) != 0, nr,
              $urandom_range(0, 3) != 0, 16'($urandom));
         chk_model($sformatf("rnd%0d", i));
         if ($urandom_range(0, 79) == 0) begin
            reset = 1'b1;
            #1;
            mdl_reset();
            chk_model($sformatf("rndrst%0d", i));
            @(negedge clk);
            reset = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
